// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// A mult/div takes WIDTH RUN cycles plus one FIX cycle; MTHI/MTLO write in a single edge.
module mips_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  localparam logic [5:0] LastIter = 6'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   abs_rs, abs_rt;
  logic [WIDTH:0]     add_sum, shifted;
  logic               ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, remd, dividend;

  always_comb begin
    // op[0] clear selects the signed variants (MULT/DIV)
    rs_neg   = ~op[0] & rs_data[WIDTH-1];
    rt_neg   = ~op[0] & rt_data[WIDTH-1];
    abs_rs   = rs_neg ? -rs_data : rs_data;
    abs_rt   = rt_neg ? -rt_data : rt_data;
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    shifted  = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    ge       = shifted >= {1'b0, b_q};
    prod     = neg_q ? -acc_q : acc_q;
    quot     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remd     = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    // Re-signing the magnitude recovers the original rs_data for divide-by-zero
    dividend = rneg_q ? -a_q : a_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (!op[2]) begin
            a_d      = abs_rs;
            b_d      = abs_rt;
            neg_d    = rs_neg ^ rt_neg;
            rneg_d   = rs_neg;
            is_div_d = op[1];
            dz_d     = op[1] && (rt_data == '0);
            // Multiply shifts the multiplier out of the low half; divide shifts the dividend
            acc_d    = {{WIDTH{1'b0}}, (op[1] ? abs_rs : abs_rt)};
            rem_d    = '0;
            cnt_d    = '0;
            state_d  = StRun;
          end else if (!op[1]) begin
            if (op[0]) lo_d = rs_data;
            else       hi_d = rs_data;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q + 6'd1;
        if (is_div_q) begin
          rem_d             = ge ? (shifted - {1'b0, b_q}) : shifted;
          acc_d[WIDTH-1:0]  = {acc_q[WIDTH-2:0], ge};
        end else begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == LastIter) state_d = StFix;
      end
      StFix: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (dz_q) begin
          hi_d = dividend;
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = remd;
          lo_d = quot;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: table-driven back-to-back ops with a result
// scoreboard, plus hand-written MTHI/MTLO, start-while-busy and mid-run reset sequences.
module tb_mips_muldiv;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;
  localparam logic [2:0] OpRsvd  = 3'b110;
  localparam int NumVec = 10;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int   checks;
  int   failures;
  vec_t vecs[NumVec];
  exp_t sb[$];

  mips_muldiv #(.WIDTH(32)) dut (
    .clkin  (clk),
    .reset  (rst_n),
    .start  (start),
    .op     (op),
    .rs_data(rs),
    .rt_data(rt),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives a one-cycle start strobe from the current falling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    rs    = a;
    rt    = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.hi = h;
    e.lo = l;
    sb.push_back(e);
  endtask

  // Counts busy cycles until done is seen, bounded so a dead DUT cannot hang the run.
  task automatic wait_done(output int nb);
    int guard;
    guard = 0;
    nb    = 0;
    while (done !== 1'b1 && guard < 200) begin
      if (busy === 1'b1) nb++;
      guard++;
      @(negedge clk);
    end
    check("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic take_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got result expected empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      check({name, "_hi"}, hi, e.hi);
      check({name, "_lo"}, lo, e.lo);
    end
  endtask

  initial begin
    int nb;
    int busy_seen;
    checks   = 0;
    failures = 0;

    vecs[0] = '{OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{OpMult,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{OpDiv,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{OpDivu,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[4] = '{OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{OpDivu,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[6] = '{OpDiv,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[7] = '{OpDiv,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{OpMult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9] = '{OpMult,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988};

    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    rs    = '0;
    rt    = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: each op after the first is issued in the cycle its predecessor pulses done.
    push(vecs[0].ehi, vecs[0].elo);
    issue(vecs[0].op, vecs[0].a, vecs[0].b);
    for (int i = 0; i < NumVec; i++) begin
      wait_done(nb);
      check($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'd33);
      take_result($sformatf("vec%0d", i));
      if (i + 1 < NumVec) begin
        push(vecs[i+1].ehi, vecs[i+1].elo);
        issue(vecs[i+1].op, vecs[i+1].a, vecs[i+1].b);
      end else begin
        @(negedge clk);
      end
      check($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
    end

    // MTHI/MTLO land one edge after the strobe with no busy time; reserved ops do nothing.
    issue(OpMthi, 32'hDEADBEEF, 32'h0);
    check("mthi_hi", hi, 32'hDEADBEEF);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    issue(OpMtlo, 32'h0BADF00D, 32'h0);
    check("mtlo_lo", lo, 32'h0BADF00D);
    check("mtlo_hi_kept", hi, 32'hDEADBEEF);
    check("mtlo_done", {31'b0, done}, 32'd0);
    issue(OpRsvd, 32'h11111111, 32'h22222222);
    check("rsvd_hi", hi, 32'hDEADBEEF);
    check("rsvd_lo", lo, 32'h0BADF00D);
    check("rsvd_busy", {31'b0, busy}, 32'd0);

    // MULT 6 * -4 with a MULTU 5 * 5 strobe mid-run that must be dropped.
    push(32'hFFFFFFFF, 32'hFFFFFFE8);
    issue(OpMult, 32'd6, 32'hFFFFFFFC);
    repeat (5) @(negedge clk);
    issue(OpMultu, 32'd5, 32'd5);
    wait_done(nb);
    check("repulse_busy_cycles", 32'(nb + 6), 32'd33);
    take_result("repulse");
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) busy_seen++;
    end
    check("repulse_no_second_op", 32'(busy_seen), 32'd0);
    check("repulse_hi_kept", hi, 32'hFFFFFFFF);

    // Reset in the middle of a DIVU abandons it; a fresh MULTU then runs normally.
    issue(OpDivu, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("postrst_busy", {31'b0, busy}, 32'd0);
    check("postrst_lo", lo, 32'd0);
    push(32'd0, 32'd6);
    issue(OpMultu, 32'd2, 32'd3);
    wait_done(nb);
    check("postrst_busy_cycles", 32'(nb), 32'd33);
    take_result("postrst");
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
